// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// State encoding, idle row pattern, code/entry widths and two small decode helpers.
package keypad_pkg;

   localparam int unsigned CODE_W  = 4;
   localparam int unsigned ENTRY_W = 16;

   // Rows are active-low; all high means no key in the driven column.
   localparam logic [3:0] ROWS_IDLE = 4'b1111;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   // Lowest-numbered low row wins when several keys share a column.
   function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
      logic [1:0] idx;
      if (!r[0]) begin
         idx = 2'd0;
      end else if (!r[1]) begin
         idx = 2'd1;
      end else if (!r[2]) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

   // One-hot-low column drive for a column index.
   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running prescaler: counts 0..SCAN_DIV-1 and raises tick for the single
// cycle where the count sits at its terminal value. Synchronous active-high reset.
// Also suitable for pacing a seven-segment display refresh.
module keypad_tick_gen #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] count;

   // Prescaler counter, wraps at the terminal value.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == CNT_LAST);

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner. Drives columns one-hot-low, debounces presses and
// releases over DEBOUNCE_TICKS scan ticks, and shifts each accepted key code
// into a 16-bit entry register (newest digit in the low nibble).
// Optional build macro KEYPAD_AUTOREPEAT_EN: while a key stays held, a repeat
// accept is emitted every REPEAT_TICKS ticks.
module hex_keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_TICKS = 8,
   parameter int unsigned REPEAT_TICKS   = 400
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [3:0]           rows,
   input  logic                 clear,
   output logic [3:0]           cols,
   output logic                 key_valid,
   output logic [CODE_W-1:0]    key_code,
   output logic                 key_held,
   output logic [ENTRY_W-1:0]   number
);

   if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
      $error("hex_keypad_scanner: illegal parameter value");
   end

   // Counters reach DEBOUNCE_TICKS at most; a tick that finds the count at
   // DEB_LAST is the one that completes the debounce window.
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
   logic [REP_W-1:0] rep_cnt;
`endif

   logic [3:0]        rows_meta;
   logic [3:0]        rs;
   logic              tick;
   state_t            state;
   logic [1:0]        col_idx;
   logic [1:0]        row_idx;
   logic [DEB_W-1:0]  deb_cnt;
   logic [DEB_W-1:0]  rel_cnt;

   logic              row_hit;
   logic [1:0]        low_row;
   logic              same_row;
   logic              accept_now;
   logic              repeat_now;
   logic              emit;
   logic [CODE_W-1:0] cur_code;

   keypad_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick_gen (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   // Two-flop synchronizer for the asynchronous row lines.
   always_ff @(posedge clock) begin
      if (reset) begin
         rows_meta <= ROWS_IDLE;
         rs        <= ROWS_IDLE;
      end else begin
         rows_meta <= rows;
         rs        <= rows_meta;
      end
   end

   assign row_hit  = (rs != ROWS_IDLE);
   assign low_row  = lowest_low_row(rs);
   assign same_row = row_hit && (low_row == row_idx);
   assign cur_code = {row_idx, col_idx};

   // A press completes its debounce window on this tick.
   assign accept_now = tick && (state == DEBOUNCE) && same_row && (deb_cnt >= DEB_LAST);

`ifdef KEYPAD_AUTOREPEAT_EN
   assign repeat_now = tick && (state == HELD) && row_hit && (rep_cnt >= REP_LAST);
`else
   assign repeat_now = 1'b0;
`endif

   assign emit = accept_now | repeat_now;

   // Scan/debounce/hold state machine with registered column drive and key_held.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= SCAN;
         col_idx  <= 2'd0;
         cols     <= 4'b1110;
         row_idx  <= 2'd0;
         deb_cnt  <= '0;
         rel_cnt  <= '0;
         key_held <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt  <= '0;
`endif
      end else if (tick) begin
         case (state)
            SCAN: begin
               if (row_hit) begin
                  // Lock on this column; col_idx stays put while debouncing.
                  row_idx <= low_row;
                  deb_cnt <= DEB_W'(1);
                  state   <= DEBOUNCE;
               end else begin
                  col_idx <= col_idx + 2'd1;
                  cols    <= col_drive(col_idx + 2'd1);
               end
            end

            DEBOUNCE: begin
               if (same_row) begin
                  deb_cnt <= deb_cnt + 1'b1;
                  if (deb_cnt >= DEB_LAST) begin
                     state    <= HELD;
                     key_held <= 1'b1;
                     rel_cnt  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rep_cnt  <= '0;
`endif
                  end
               end else begin
                  // Bounce or different row: drop the candidate silently.
                  deb_cnt <= '0;
                  state   <= SCAN;
                  col_idx <= col_idx + 2'd1;
                  cols    <= col_drive(col_idx + 2'd1);
               end
            end

            HELD: begin
               if (!row_hit) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                  rep_cnt <= '0;
`endif
                  if (rel_cnt >= DEB_LAST) begin
                     rel_cnt  <= '0;
                     deb_cnt  <= '0;
                     key_held <= 1'b0;
                     state    <= SCAN;
                     col_idx  <= col_idx + 2'd1;
                     cols     <= col_drive(col_idx + 2'd1);
                  end else begin
                     rel_cnt <= rel_cnt + 1'b1;
                  end
               end else begin
                  rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                  if (rep_cnt >= REP_LAST) begin
                     rep_cnt <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
`endif
               end
            end

            default: begin
               state    <= SCAN;
               col_idx  <= 2'd0;
               cols     <= 4'b1110;
               key_held <= 1'b0;
            end
         endcase
      end
   end

   // Accept pulse, last code and entry shift register; an accept on the same
   // edge as clear keeps only the new digit.
   always_ff @(posedge clock) begin
      if (reset) begin
         key_valid <= 1'b0;
         key_code  <= '0;
         number    <= '0;
      end else begin
         key_valid <= emit;
         if (emit) begin
            key_code <= cur_code;
            if (clear) begin
               number <= {{(ENTRY_W - CODE_W){1'b0}}, cur_code};
            end else begin
               number <= {number[ENTRY_W-CODE_W-1:0], cur_code};
            end
         end else if (clear) begin
            number <= '0;
         end
      end
   end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3.
// A keypad model pulls a row low when a pressed key's column is driven low.
// Expected entry values come from a digit-queue model: each accepted press
// appends its hex code, clear empties the entry.
module tb_hex_keypad_scanner;

   logic        clock;
   logic        reset;
   logic [3:0]  rows;
   logic        clear;
   logic [3:0]  cols;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [15:0] number;

   logic [15:0] pressed;
   logic [15:0] exp_number;
   int          compared;
   int          mismatched;
   int          pulses;

   hex_keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_TICKS (3),
      .REPEAT_TICKS   (5)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .rows      (rows),
      .clear     (clear),
      .cols      (cols),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_held  (key_held),
      .number    (number)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Keypad: key k sits at row k/4, column k%4.
   always_comb begin
      rows = 4'b1111;
      for (int k = 0; k < 16; k++) begin
         if (pressed[k] && (cols[k % 4] == 1'b0)) rows[k / 4] = 1'b0;
      end
   end

   always @(negedge clock) begin
      if (key_valid === 1'b1) pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int val, input int lo, input int hi);
      compared++;
      assert (val >= lo && val <= hi) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
      end
   endtask

   task automatic wait_cols(input logic [3:0] val, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (cols !== val && n < 64);
      check(tag, cols, val);
   endtask

   // Wait (bounded) for an accept, then check code and entry against the model.
   task automatic wait_accept(input logic [3:0] code, input string tag);
      int n;
      n = 0;
      while (key_valid !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_seen"}, key_valid, 1'b1);
      exp_number = {exp_number[11:0], code};
      check({tag, "_code"}, key_code, code);
      check({tag, "_number"}, number, exp_number);
   endtask

   // Release everything, wait (bounded) for key_held to drop, check pulse count.
   task automatic wait_release(input int base, input int exp_pulses, input string tag);
      int n;
      pressed = '0;
      n = 0;
      while (key_held !== 1'b0 && n < 40) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_released"}, key_held, 1'b0);
      repeat (2) @(negedge clock);
      check({tag, "_pulses"}, pulses - base, exp_pulses);
   endtask

   task automatic press_release(input logic [15:0] keys, input logic [3:0] code,
                                input int hold, input string tag);
      int base;
      base = pulses;
      pressed = keys;
      wait_accept(code, tag);
      repeat (hold) @(negedge clock);
      check({tag, "_held"}, key_held, 1'b1);
      wait_release(base, 1, tag);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      exp_number = '0;
      check("clear_number", number, 16'h0000);
   endtask

   initial begin
      int          base;
      int          n;
      logic [3:0]  cur;
      logic [15:0] keys;
      logic [3:0]  code;
      int          c;
      int          r1;
      int          r2;

      compared   = 0;
      mismatched = 0;
      pulses     = 0;
      pressed    = '0;
      clear      = 1'b0;
      exp_number = '0;
      reset      = 1'b1;

      // Reset values and idle column rotation.
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check("rst_cols", cols, 4'b1110);
      check("rst_number", number, 16'h0000);
      check("rst_valid", key_valid, 1'b0);
      check("rst_code", key_code, 4'h0);
      check("rst_held", key_held, 1'b0);
      wait_cols(4'b1101, "rot_first");
      cur = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         repeat (3) @(negedge clock);
         check("rot_hold", cols, cur);
         @(negedge clock);
         cur = {cur[2:0], cur[3]};
         check("rot_step", cols, cur);
      end

      // Key 6 held: one accept, key_held until three idle ticks after release.
      base = pulses;
      pressed = 16'h0040;
      wait_accept(4'h6, "k6");
      repeat (12) @(negedge clock);
      check("k6_held", key_held, 1'b1);
      check("k6_one_pulse", pulses - base, 1);
      pressed = '0;
      n = 0;
      while (key_held !== 1'b0 && n < 30) begin
         @(negedge clock);
         n++;
      end
      check_range("k6_release_latency", n, 11, 14);
      repeat (2) @(negedge clock);
      check("k6_pulses", pulses - base, 1);

      // Key 3 pressed for only two ticks: rejected, rotation resumes.
      wait_cols(4'b1110, "glitch_sync");
      base = pulses;
      pressed = 16'h0008;
      wait_cols(4'b0111, "glitch_col3");
      repeat (8) @(negedge clock);
      pressed = '0;
      wait_cols(4'b1110, "glitch_resume0");
      wait_cols(4'b1101, "glitch_resume1");
      repeat (20) @(negedge clock);
      check("glitch_pulses", pulses - base, 0);
      check("glitch_number", number, exp_number);
      check("glitch_held", key_held, 1'b0);

      // Digits 1..5 in turn; the oldest nibble falls off the top.
      pulse_clear();
      for (int d = 1; d <= 5; d++) begin
         press_release(16'h0001 << d, 4'(d), 4, "seq");
      end
      check("seq_final", number, 16'h2345);

      // Clear on the same edge as the accept of key A.
      pulse_clear();
      for (int d = 1; d <= 4; d++) begin
         press_release(16'h0001 << d, 4'(d), 2, "pre");
      end
      check("pre_1234", number, 16'h1234);
      wait_cols(4'b1110, "clr_sync");
      base = pulses;
      pressed = 16'h0400;
      wait_cols(4'b1011, "clr_col2");
      repeat (11) @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      exp_number = 16'h000A;
      check("clr_accept_valid", key_valid, 1'b1);
      check("clr_accept_code", key_code, 4'hA);
      check("clr_accept_number", number, 16'h000A);
      wait_release(base, 1, "clr");

      // Reset while debouncing key 9: no accept; key re-accepted afterwards.
      wait_cols(4'b1110, "rdb_sync");
      base = pulses;
      pressed = 16'h0200;
      wait_cols(4'b1101, "rdb_col1");
      repeat (6) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      exp_number = '0;
      check("rdb_cols", cols, 4'b1110);
      check("rdb_valid", key_valid, 1'b0);
      check("rdb_held", key_held, 1'b0);
      check("rdb_number", number, 16'h0000);
      check("rdb_code", key_code, 4'h0);
      check("rdb_no_pulse", pulses - base, 0);
      wait_accept(4'h9, "rdb_again");
      wait_release(base, 1, "rdb");

`ifdef KEYPAD_AUTOREPEAT_EN
      // Held for 12 ticks past the accept: original plus two repeats.
      base = pulses;
      pressed = 16'h0080;
      wait_accept(4'h7, "rep");
      repeat (48) @(negedge clock);
      check("rep_held", key_held, 1'b1);
      exp_number = {exp_number[7:0], 4'h7, 4'h7};
      wait_release(base, 3, "rep");
      check("rep_number", number, exp_number);
`endif

      // Random presses, sometimes two rows in one column, sometimes a clear.
      for (int it = 0; it < 12; it++) begin
         if ($urandom_range(0, 3) == 0) pulse_clear();
         c  = $urandom_range(0, 3);
         r1 = $urandom_range(0, 3);
         keys = 16'h0001 << (4 * r1 + c);
         code = 4'(4 * r1 + c);
         if ($urandom_range(0, 2) == 0) begin
            r2 = (r1 + $urandom_range(1, 3)) % 4;
            keys = keys | (16'h0001 << (4 * r2 + c));
            if (r2 < r1) code = 4'(4 * r2 + c);
         end
         press_release(keys, code, $urandom_range(0, 8), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
